// File: rtl/disp_arb_pkg.sv
// Shared types and constants for the display-sharing arbiter.
// The round-robin helpers are also used by the selection sub-module.
package disp_arb_pkg;
  localparam int NUM_REQ = 3;
  localparam int NUM_DIG = 6;
  localparam logic [7:0] BLANK    = 8'h10;
  localparam logic [1:0] NO_OWNER = 2'd3;

  typedef enum logic [1:0] {IDLE, GRANT, HOLD, RELEASE} arb_state_t;

  typedef logic [NUM_DIG-1:0][7:0]  disp_bus_t;
  typedef logic [NUM_REQ-1:0][23:0] val_bus_t;

  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [NUM_REQ-1:0] idx2oh(input logic [1:0] i);
    return 3'b001 << i;
  endfunction
endpackage

// File: rtl/disp_share_arbiter_rr_pick3.sv
// Combinational round-robin pick among three requesters,
// searching upward from the slot after the last owner.
module rr_pick3
  import disp_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] idx
);
  logic [1:0] c0, c1, c2;

  assign c0 = rr_next(last);
  assign c1 = rr_next(c0);
  assign c2 = rr_next(c1);

  always_comb begin
    valid = 1'b1;
    idx   = 2'd0;
    if (req[c0])      idx = c0;
    else if (req[c1]) idx = c1;
    else if (req[c2]) idx = c2;
    else              valid = 1'b0;
  end
endmodule

// File: rtl/disp_share_arbiter.sv
// Shares one six-digit hex display between three requesters with
// round-robin arbitration, a minimum tenure and a preemptible maximum tenure.
module disp_share_arbiter
  import disp_arb_pkg::*;
#(
  parameter logic [15:0] TICK_DIV = 16'd49999,
  parameter int          MIN_HOLD = 500,
  parameter int          MAX_HOLD = 3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [23:0] val0,
  input  logic [23:0] val1,
  input  logic [23:0] val2,
  output logic [2:0]  gnt,
  output logic [1:0]  owner,
  output logic        busy,
  output logic [7:0]  data0,
  output logic [7:0]  data1,
  output logic [7:0]  data2,
  output logic [7:0]  data3,
  output logic [7:0]  data4,
  output logic [7:0]  data5
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] MIN_C = HW'(MIN_HOLD);
  localparam logic [HW-1:0] MAX_C = HW'(MAX_HOLD);

  arb_state_t   state_q, state_d;
  logic [15:0]  tick_cnt;
  logic         tick;
  logic [HW-1:0] hold_cnt;
  logic [1:0]   win, last_owner;
  logic         pick_vld;
  logic [1:0]   pick_idx;
  logic [2:0]   other_req;
  val_bus_t     vals;
  disp_bus_t    live, data_q;

  assign tick      = (tick_cnt == TICK_DIV);
  assign vals      = {val2, val1, val0};
  assign other_req = req & ~idx2oh(win);
  assign busy      = (state_q == GRANT) || (state_q == HOLD);

  rr_pick3 u_pick (
    .req   (req),
    .last  (last_owner),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // One digit lane per nibble; digit 0 carries the most significant nibble.
  for (genvar k = 0; k < NUM_DIG; k++) begin : g_dig
    assign live[k] = {4'h0, vals[win][23-4*k -: 4]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = GRANT;
      GRANT:   state_d = HOLD;
      HOLD:    if ((!req[win] && hold_cnt >= MIN_C) ||
                   (hold_cnt == MAX_C && |other_req)) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Release outputs are loaded on the HOLD exit edge so the RELEASE cycle
  // itself already shows a blank display and no grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt        <= '0;
      owner      <= NO_OWNER;
      data_q     <= {NUM_DIG{BLANK}};
      hold_cnt   <= '0;
      win        <= '0;
      last_owner <= 2'd2;
    end else begin
      case (state_q)
        IDLE: begin
          gnt    <= '0;
          owner  <= NO_OWNER;
          data_q <= {NUM_DIG{BLANK}};
          if (pick_vld) win <= pick_idx;
        end
        GRANT: begin
          gnt      <= idx2oh(win);
          owner    <= win;
          hold_cnt <= '0;
        end
        HOLD: begin
          if (tick && hold_cnt != MAX_C) hold_cnt <= hold_cnt + HW'(1);
          if (state_d == RELEASE) begin
            gnt        <= '0;
            owner      <= NO_OWNER;
            data_q     <= {NUM_DIG{BLANK}};
            last_owner <= win;
          end else if (req[win]) begin
            data_q <= live;
          end
        end
        default: begin
          gnt    <= '0;
          owner  <= NO_OWNER;
          data_q <= {NUM_DIG{BLANK}};
        end
      endcase
    end
  end

  assign data0 = data_q[0];
  assign data1 = data_q[1];
  assign data2 = data_q[2];
  assign data3 = data_q[3];
  assign data4 = data_q[4];
  assign data5 = data_q[5];
endmodule

// File: tb/tb_disp_share_arbiter.sv
// Self-checking bench for disp_share_arbiter with TICK_DIV=3, MIN_HOLD=2, MAX_HOLD=5.
// Slot n means 1 time unit after the n-th rising edge following reset release.
module tb_disp_share_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0;
  logic [23:0] val0 = '0, val1 = '0, val2 = '0;
  logic [2:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic [7:0]  data0, data1, data2, data3, data4, data5;
  logic [47:0] disp;
  int checks = 0;
  int errors = 0;

  localparam logic [47:0] ALL_BLANK = {6{8'h10}};

  always #5 clk = ~clk;

  disp_share_arbiter #(.TICK_DIV(16'd3), .MIN_HOLD(2), .MAX_HOLD(5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .val0(val0), .val1(val1), .val2(val2),
    .gnt(gnt), .owner(owner), .busy(busy),
    .data0(data0), .data1(data1), .data2(data2),
    .data3(data3), .data4(data4), .data5(data5)
  );

  assign disp = {data0, data1, data2, data3, data4, data5};

  typedef struct {
    logic [2:0]  req;
    logic [23:0] v0, v1, v2;
    logic [2:0]  gnt;
    logic [1:0]  owner;
    logic [47:0] data;
  } vec_t;

  typedef struct {
    logic [2:0] gnt;
    int         gap;
    int         len;
  } ten_t;

  vec_t vecs[6];
  vec_t vec_q[$];
  ten_t ten_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns at a falling edge with reset just released: that instant is slot 0.
  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits for a grant, then measures how many cycles it stays unchanged.
  task automatic tenure(output logic [2:0] g, output int gap, output int len);
    gap = 0;
    while (gnt == 3'b000 && gap < 200) begin
      step();
      gap++;
    end
    g   = gnt;
    len = 0;
    while (g != 3'b000 && gnt == g && len < 200) begin
      len++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, n;
    vec_t e;
    ten_t t;
    logic [2:0] g;
    int gap, len;

    vecs[0] = '{req:3'b001, v0:24'h12AB3F, v1:24'h000000, v2:24'hFFFFFF, gnt:3'b001, owner:2'd0, data:48'h01020A0B030F};
    vecs[1] = '{req:3'b110, v0:24'h111111, v1:24'hA5C3E1, v2:24'h222222, gnt:3'b010, owner:2'd1, data:48'h0A050C030E01};
    vecs[2] = '{req:3'b100, v0:24'h333333, v1:24'h444444, v2:24'h0F1E2D, gnt:3'b100, owner:2'd2, data:48'h000F010E020D};
    vecs[3] = '{req:3'b111, v0:24'h987654, v1:24'h555555, v2:24'h666666, gnt:3'b001, owner:2'd0, data:48'h090807060504};
    vecs[4] = '{req:3'b011, v0:24'h000000, v1:24'hFFFFFF, v2:24'h777777, gnt:3'b001, owner:2'd0, data:48'h000000000000};
    vecs[5] = '{req:3'b010, v0:24'h888888, v1:24'hFEDCBA, v2:24'h999999, gnt:3'b010, owner:2'd1, data:48'h0F0E0D0C0B0A};

    // Reset state with no requests stays idle.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle gnt/owner/busy", {gnt, owner, busy}, {3'b000, 2'd3, 1'b0});
      chk("idle data", disp, ALL_BLANK);
    end

    // Table: first grant out of reset, latency and digit mapping.
    foreach (vecs[i]) begin
      do_reset();
      req = vecs[i].req; val0 = vecs[i].v0; val1 = vecs[i].v1; val2 = vecs[i].v2;
      vec_q.push_back(vecs[i]);
      step();
      chk("vec no grant at slot1", gnt, 3'b000);
      n = 1;
      while (gnt == 3'b000 && n < 20) begin
        step();
        n++;
      end
      e = vec_q.pop_front();
      chk("vec latency", n, 2);
      chk("vec gnt", gnt, e.gnt);
      chk("vec owner", owner, e.owner);
      chk("vec busy", busy, 1'b1);
      step();
      chk("vec data", disp, e.data);
      req = '0;
    end

    // Short request: grant held to MIN_HOLD with data frozen, then RELEASE, then IDLE.
    do_reset();
    step(3);
    req = 3'b001; val0 = 24'h12AB3F;
    step(2);
    chk("minhold gnt", gnt, 3'b001);
    step();
    chk("minhold data", disp, 48'h01020A0B030F);
    step();
    req = '0; val0 = 24'h555555;
    len = 0; bad = 0;
    while (gnt == 3'b001 && len < 40) begin
      if (disp !== 48'h01020A0B030F) bad++;
      len++;
      step();
    end
    chk("minhold tail length", len, 6);
    chk("minhold frozen data", bad, 0);
    chk("minhold release gnt/owner/busy", {gnt, owner, busy}, {3'b000, 2'd3, 1'b0});
    chk("minhold release data", disp, ALL_BLANK);
    step();
    chk("minhold idle busy", busy, 1'b0);
    req = 3'b001;
    step(2);
    chk("rerequest same owner gnt", gnt, 3'b001);
    chk("rerequest same owner owner", owner, 2'd0);
    req = '0;

    // All three requesting: round-robin order with MAX_HOLD tenures.
    do_reset();
    req = 3'b111;
    ten_q.push_back('{gnt:3'b001, gap:2, len:19});
    ten_q.push_back('{gnt:3'b010, gap:3, len:21});
    ten_q.push_back('{gnt:3'b100, gap:3, len:21});
    ten_q.push_back('{gnt:3'b001, gap:3, len:21});
    for (int k = 0; k < 4; k++) begin
      tenure(g, gap, len);
      t = ten_q.pop_front();
      chk("rr gnt", g, t.gnt);
      chk("rr gap", gap, t.gap);
      chk("rr length", len, t.len);
    end
    req = '0;

    // Owner 1 alone keeps the display past MAX_HOLD; req2 then preempts.
    do_reset();
    req = 3'b010; val1 = 24'hC0FFEE;
    step(2);
    chk("sat gnt", gnt, 3'b010);
    bad = 0;
    for (int c = 3; c <= 28; c++) begin
      step();
      if (gnt !== 3'b010) bad++;
    end
    chk("sat no release", bad, 0);
    chk("sat data", disp, 48'h0C000F0F0E0E);
    req = 3'b110;
    step();
    chk("preempt release gnt/owner", {gnt, owner}, {3'b000, 2'd3});
    chk("preempt release data", disp, ALL_BLANK);
    step(3);
    chk("preempt next gnt", gnt, 3'b100);
    chk("preempt next owner", owner, 2'd2);
    req = '0;

    // Asynchronous reset in the middle of owner 2's tenure.
    do_reset();
    req = 3'b100; val2 = 24'hABCDEF;
    step(6);
    chk("midhold gnt", gnt, 3'b100);
    chk("midhold data", disp, 48'h0A0B0C0D0E0F);
    rst_n = 1'b0;
    #2;
    chk("async reset gnt/owner/busy", {gnt, owner, busy}, {3'b000, 2'd3, 1'b0});
    chk("async reset data", disp, ALL_BLANK);
    req = 3'b101;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post reset grant phase", busy, 1'b1);
    step();
    chk("post reset gnt", gnt, 3'b001);
    chk("post reset owner", owner, 2'd0);
    req = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/disp_share_arbiter.md
DISP_SHARE_ARBITER -- requirements
Module: disp_share_arbiter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 16'd49999, meaning tick period minus one in clk cycles (1 kHz at 50 MHz).
REQ-002 SHALL have parameter MIN_HOLD, default 500, meaning the minimum ownership time in ticks.
REQ-003 SHALL have parameter MAX_HOLD, default 3000, meaning the ownership time in ticks after which a waiting requester may preempt; MAX_HOLD > MIN_HOLD >= 1.
REQ-004 SHALL have ports:
  clk  input  1  system clock, single clock domain;
  rst_n  input  1  asynchronous active-low reset;
  req  input  3  per-requester display request, level;
  val0, val1, val2  input  24 each  value of requester 0/1/2 shown as six hex nibbles;
  gnt  output  3  one-hot grant, registered;
  owner  output  2  index of the current owner, 2'd3 when none;
  busy  output  1  high in GRANT and HOLD;
  data0..data5  output  8 each  digit codes for the six-digit display, data0 = DIG1.

Function
REQ-005 SHALL run a free-running tick counter 0..TICK_DIV; tick = one-cycle pulse when the count equals TICK_DIV.
REQ-006 SHALL implement FSM states IDLE, GRANT, HOLD, RELEASE.
REQ-007 IDLE: if any req bit is high, SHALL select the winner round-robin, searching from last_owner+1 modulo 3, and SHALL go to GRANT next cycle; otherwise SHALL stay in IDLE.
REQ-008 GRANT (one cycle): SHALL set gnt one-hot and owner to the winner, SHALL clear hold_cnt, and SHALL go to HOLD.
REQ-009 HOLD: hold_cnt SHALL increment on each tick and saturate at MAX_HOLD.
REQ-010 HOLD: while req[owner] is high, dataK SHALL be {4'h0, nibble K of val[owner]}, with data0 = bits[23:20] and data5 = bits[3:0], registered with 1-cycle latency.
REQ-011 HOLD: if req[owner] falls before hold_cnt reaches MIN_HOLD, the data outputs SHALL freeze at their last value and the grant SHALL be kept until hold_cnt = MIN_HOLD.
REQ-012 HOLD -> RELEASE SHALL occur when (req[owner]==0 and hold_cnt>=MIN_HOLD) or (hold_cnt==MAX_HOLD and any other req bit is high); if no other request is pending, ownership SHALL continue past MAX_HOLD.
REQ-013 RELEASE (one cycle): SHALL clear gnt to 0, set owner to 3, set every data output to BLANK (8'h10, which the display decodes as all segments off), set last_owner to the releasing owner, and go to IDLE.
REQ-014 IDLE: data outputs SHALL be BLANK, gnt SHALL be 0, and owner SHALL be 3.
REQ-015 A req rising while the block is in GRANT, HOLD or RELEASE SHALL be held pending only by its level; there SHALL be no request latching.
REQ-016 Simultaneous requests in IDLE SHALL resolve solely by the round-robin pointer, and at most one gnt bit SHALL be set in any cycle.
REQ-017 Re-request by the same owner after RELEASE SHALL be allowed, but only when no other request is pending (fairness).

Reset
REQ-018 On rst_n low, asynchronously: state=IDLE, gnt=0, owner=3, busy=0, data0..data5=8'h10, hold_cnt=0, tick counter=0, last_owner=2 (so requester 0 has first priority).
REQ-019 Reset asserted mid-HOLD SHALL drop the grant immediately, and the first cycle after release SHALL be IDLE evaluation.

Structure
REQ-020 Package disp_arb_pkg SHALL hold the state enum, NUM_REQ=3, BLANK=8'h10, and NO_OWNER=2'd3.
REQ-021 The round-robin selection SHALL be a combinational sub-module rr_pick3 (inputs req[2:0] and last[1:0]; outputs valid and idx[1:0]).

Verification (bench parameters: TICK_DIV=3, MIN_HOLD=2, MAX_HOLD=5)
REQ-022 Reset release, req=0 -> gnt=0, owner=3, data0..5=8'h10 indefinitely.
REQ-023 req=3'b001, val0=24'h12AB3F -> gnt=001 two cycles after req; data0..5 = 01,02,0A,0B,03,0F one cycle after HOLD entry.
REQ-024 req0 pulse for 1 tick -> gnt held until hold_cnt=2 (8 cycles of HOLD), data frozen at last value, then one BLANK RELEASE cycle, then IDLE.
REQ-025 req=3'b111 held from reset -> grants in order 0, 1, 2, 0; each tenure ends at hold_cnt=5; one RELEASE cycle between tenures.
REQ-026 Owner 1 holding with no other request beyond 5 ticks -> no release; req2 raised at tick 7 -> RELEASE next cycle, then gnt=100.
REQ-027 rst_n pulsed low mid-HOLD of owner 2 -> gnt=0 and data=8'h10 in the same cycle; after release, with req=3'b101, requester 0 is granted first.
